// File: rtl/vic_pkg.sv
// Shared constants for the vectored interrupt controller.
package vic_pkg;

    localparam int unsigned N_SRC  = 31;
    localparam int unsigned ADDR_W = 5;

    // Vector address reported when nothing is pending.
    localparam logic [ADDR_W-1:0] NO_IRQ = 5'h1F;

    // Bit positions inside one per-source configuration nibble.
    localparam int unsigned CFG_LEVEL = 0;
    localparam int unsigned CFG_RISE  = 1;
    localparam int unsigned CFG_FALL  = 2;
    localparam int unsigned CFG_EN    = 3;

endpackage

// File: rtl/vic_irq_src.sv
// One interrupt source: input history register, edge/level detection and
// the pending flop with set/clear.
module vic_irq_src
    import vic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ext,
    input  logic [3:0] cfg,
    input  logic       clr,
    output logic       pending
);

    logic ext_q;
    logic rise;
    logic fall;
    logic trig;

    // Edge detection against the previous sample; level mode overrides edges.
    always_comb begin
        rise = ext & ~ext_q;
        fall = ~ext & ext_q;
        if (cfg[CFG_LEVEL]) begin
            trig = ext;
        end else begin
            trig = (rise & cfg[CFG_RISE]) | (fall & cfg[CFG_FALL]);
        end
    end

    // Previous input sample; cleared by reset so the first sample compares to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= ext;
        end
    end

    // Pending flop: edge requests latch until acknowledged, a trigger in the
    // acknowledge cycle wins; level requests follow the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (!cfg[CFG_EN]) begin
            pending <= 1'b0;
        end else if (cfg[CFG_LEVEL]) begin
            pending <= ext & ~clr;
        end else if (trig) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/vic_irq.sv
// Vectored interrupt controller front end: per-source detection, fixed
// priority selection (source 0 highest), acknowledge handling and
// registered IRQ / vector outputs.
module vic_irq #(
    parameter int unsigned N_SRC  = vic_pkg::N_SRC,
    parameter int unsigned ADDR_W = vic_pkg::ADDR_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_IRQ,
    output logic                 o_IRQ,
    input  logic [4*N_SRC-1:0]   i_reg,
    input  logic [N_SRC-1:0]     i_ext,
    input  logic                 i_en,
    output logic [ADDR_W-1:0]    o_irq_addr
);

    import vic_pkg::*;

    localparam logic [ADDR_W-1:0] NONE = '1;

    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  clr;
    logic [ADDR_W-1:0] sel;
    logic              ack_q;
    logic              ack_rise;
    logic              in_service;

    for (genvar n = 0; n < N_SRC; n++) begin : g_src
        vic_irq_src u_src (
            .clk     (i_clk),
            .rst     (i_rst),
            .ext     (i_ext[n]),
            .cfg     (i_reg[4*n +: 4]),
            .clr     (clr[n]),
            .pending (pending[n])
        );
    end

    // Lowest-index pending source wins; NONE when nothing is pending.
    always_comb begin
        logic found;
        sel   = NONE;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (pending[i] && !found) begin
                sel   = ADDR_W'(i);
                found = 1'b1;
            end
        end
    end

    // Acknowledge rising edge clears the source currently presented to the CPU.
    always_comb begin
        ack_rise = i_IRQ & ~ack_q;
        clr      = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            clr[i] = ack_rise && (o_irq_addr == ADDR_W'(i));
        end
    end

    // Acknowledge tracking, in-service flag and registered outputs; the
    // vector is held while in service so the CPU reads a stable address.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_q      <= 1'b0;
            in_service <= 1'b0;
            o_IRQ      <= 1'b0;
            o_irq_addr <= NONE;
        end else begin
            ack_q <= i_IRQ;
            if (ack_rise) begin
                in_service <= 1'b1;
            end else if (!i_IRQ) begin
                in_service <= 1'b0;
            end
            o_IRQ <= i_en & ~in_service & (|pending);
            if (!in_service) begin
                o_irq_addr <= sel;
            end
        end
    end

endmodule

// File: tb/tb_vic_irq.sv
// Directed self-checking bench for vic_irq.
module tb_vic_irq;

    logic         clk;
    logic         rst;
    logic         i_IRQ;
    logic         o_IRQ;
    logic [123:0] i_reg;
    logic [30:0]  i_ext;
    logic         i_en;
    logic [4:0]   o_irq_addr;

    int n_tests;
    int n_fail;

    vic_irq #(.N_SRC(31), .ADDR_W(5)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_IRQ      (i_IRQ),
        .o_IRQ      (o_IRQ),
        .i_reg      (i_reg),
        .i_ext      (i_ext),
        .i_en       (i_en),
        .o_irq_addr (o_irq_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic exp_irq, input logic [4:0] exp_addr);
        n_tests++;
        assert (o_IRQ === exp_irq) else begin
            n_fail++;
            $error("FAIL %s.irq: observed %b expected %b", tag, o_IRQ, exp_irq);
        end
        n_tests++;
        assert (o_irq_addr === exp_addr) else begin
            n_fail++;
            $error("FAIL %s.addr: observed %h expected %h", tag, o_irq_addr, exp_addr);
        end
    endtask

    // Two-clock acknowledge pulse followed by two idle clocks.
    task automatic do_ack();
        i_IRQ = 1'b1;
        tick();
        tick();
        i_IRQ = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        i_IRQ   = 1'b0;
        i_reg   = '0;
        i_ext   = '0;
        i_en    = 1'b1;

        // Reset held with toggling inputs.
        for (int i = 0; i < 3; i++) begin
            i_ext = ~i_ext;
            tick();
        end
        check_out("reset_hold", 1'b0, 5'h1F);
        i_ext = '0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_out("reset_release", 1'b0, 5'h1F);

        // Falling-edge source 0.
        i_reg[3:0] = 4'b1100;
        i_ext[0]   = 1'b1;
        tick();
        tick();
        tick();
        check_out("fall_ignores_rise", 1'b0, 5'h1F);
        i_ext[0] = 1'b0;
        tick();
        check_out("fall_latency1", 1'b0, 5'h1F);
        tick();
        check_out("fall_req", 1'b1, 5'd0);
        i_IRQ = 1'b1;
        tick();
        tick();
        check_out("fall_in_service", 1'b0, 5'd0);
        i_IRQ = 1'b0;
        tick();
        tick();
        check_out("fall_acked", 1'b0, 5'h1F);

        // Level source 1 and falling-edge source 2, priority.
        i_reg        = '0;
        i_reg[7:4]   = 4'b1001;
        i_reg[11:8]  = 4'b1100;
        i_ext[1]     = 1'b1;
        i_ext[2]     = 1'b1;
        tick();
        tick();
        check_out("level_req", 1'b1, 5'd1);
        i_ext[2] = 1'b0;
        tick();
        tick();
        check_out("prio_1_over_2", 1'b1, 5'd1);
        do_ack();
        check_out("level_repend", 1'b1, 5'd1);
        i_ext[1] = 1'b0;
        tick();
        tick();
        check_out("src2_next", 1'b1, 5'd2);
        do_ack();
        check_out("src2_acked", 1'b0, 5'h1F);

        // Both-edge source 3: rise and fall are separate requests.
        i_reg        = '0;
        i_reg[15:12] = 4'b1110;
        i_ext[3]     = 1'b1;
        tick();
        tick();
        check_out("both_rise_req", 1'b1, 5'd3);
        do_ack();
        check_out("both_rise_acked", 1'b0, 5'h1F);
        i_ext[3] = 1'b0;
        tick();
        tick();
        check_out("both_fall_req", 1'b1, 5'd3);
        do_ack();
        check_out("both_fall_acked", 1'b0, 5'h1F);

        // New trigger in the acknowledge cycle keeps the request pending.
        i_ext[3] = 1'b1;
        tick();
        tick();
        check_out("sim_rise_req", 1'b1, 5'd3);
        i_ext[3] = 1'b0;
        do_ack();
        check_out("ack_vs_trig", 1'b1, 5'd3);
        do_ack();
        check_out("ack_vs_trig_done", 1'b0, 5'h1F);

        // Disabled source never requests.
        i_reg        = '0;
        i_reg[19:16] = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            i_ext[4] = ~i_ext[4];
            tick();
        end
        tick();
        check_out("src_disabled", 1'b0, 5'h1F);

        // Global mask: pending accumulates, o_IRQ held low.
        i_reg[23:20] = 4'b1010;
        i_en         = 1'b0;
        i_ext[5]     = 1'b1;
        tick();
        tick();
        tick();
        check_out("global_mask", 1'b0, 5'd5);
        i_en = 1'b1;
        tick();
        check_out("global_unmask", 1'b1, 5'd5);

        // Highest index source pending alongside source 5.
        i_reg[123:120] = 4'b1010;
        i_ext[30]      = 1'b1;
        tick();
        tick();
        check_out("prio_5_over_30", 1'b1, 5'd5);

        // Reset in the middle of service drops everything.
        i_IRQ = 1'b1;
        tick();
        check_out("ack_first_clock", 1'b1, 5'd5);
        #1;
        rst = 1'b1;
        #1;
        check_out("async_reset", 1'b0, 5'h1F);
        i_ext = '0;
        i_IRQ = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_out("pending_lost", 1'b0, 5'h1F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vic_irq.md
Name: vic_irq

Overview:
- Vectored interrupt controller front end for up to 31 external interrupt sources.
- Each source is configured as level, rising-edge, falling-edge or both-edge sensitive, with a per-source enable.
- Pending requests are latched and prioritised; the block drives one IRQ line and a 5-bit vector address to the CPU.
- The CPU acknowledges through i_IRQ; the acknowledge clears the serviced request.

Parameters:
- N_SRC, 31, number of sources (1..31); address 31 is reserved as "none".
- ADDR_W, 5, vector address width.

Ports:
- i_clk  in  1  system clock, rising-edge active.
- i_rst  in  1  reset, asynchronous, active-high.
- i_IRQ  in  1  CPU acknowledge / in-service indication.
- o_IRQ  out  1  interrupt request to the CPU.
- i_reg  in  4*N_SRC (124)  config; nibble n = i_reg[4n+3:4n]: bit3 en, bit2 fall, bit1 rise, bit0 level.
- i_ext  in  N_SRC (31)  external interrupt inputs; synchronous to i_clk.
- i_en  in  1  global interrupt enable.
- o_irq_addr  out  ADDR_W (5)  index of the highest-priority pending source; 5'h1F when none.

Behaviour:
- Reset (async, i_rst=1) clears ext_q, pending, ack_q and in_service. Outputs: o_IRQ=0, o_irq_addr=5'h1F.
- All state is updated on the rising edge of i_clk. ext_q <= i_ext every cycle.
- Edge detect: rise[n] = i_ext[n] & ~ext_q[n]; fall[n] = ~i_ext[n] & ext_q[n].
  - The first sample after reset compares against 0.
  - Inputs must be stable for at least one clock; pulses shorter than one period may be missed.
- Trigger per source (when en=1):
  - level=1: trig = i_ext[n]; level has priority over the rise/fall bits.
  - level=0: trig = (rise & cfg.rise) | (fall & cfg.fall). rise and fall both set means both edges.
  - Config nibble 1000 (en only): source never triggers.
- Pending bits:
  - Edge sources: pending[n] <= 1 on trig, and stays set until acknowledged.
  - Level sources: pending[n] <= i_ext[n] each cycle, so it follows the input.
  - en=0 forces pending[n] to 0 on the next clock.
- Priority: lowest index wins (source 0 highest). sel = index of the lowest set pending bit, or 5'h1F if none.
- Outputs are registered, each clock:
  - o_IRQ <= i_en & ~in_service & |pending.
  - o_irq_addr <= sel while not in service.
  - o_irq_addr is frozen while in_service=1 so the CPU reads a stable vector.
- Latency: an input edge between clock edges k-1 and k sets pending at clock k, and o_IRQ/o_irq_addr at clock k+1.
- Acknowledge:
  - ack_q <= i_IRQ. The rising edge of i_IRQ (i_IRQ & ~ack_q) clears pending[o_irq_addr] and sets in_service.
  - i_IRQ low clears in_service; remaining pending sources then re-assert o_IRQ on the next clock.
  - A level source whose input is still high is re-pended on the next clock.
  - No nesting; a higher-priority request arriving during service waits.
- Simultaneous events:
  - An ack clear and a new trigger on the same source in the same cycle: the new trigger wins (pending stays 1).
  - Multiple sources in the same cycle: all latch, and service follows priority order.
- i_en=0 masks o_IRQ only; pending keeps accumulating.
- Config changes take effect on the next clock; no extra edge is generated.

Decomposition:
- Package vic_pkg: N_SRC=31, ADDR_W=5, NO_IRQ=5'h1F, and CFG_LEVEL=0, CFG_RISE=1, CFG_FALL=2, CFG_EN=3 bit indices.
- Sub-module vic_irq_src, instantiated N_SRC times via generate: input sync register, edge/level detect, pending flop with set/clear.
- Priority encoder, ack logic and output registers live in the top module.

Test Plan:
- Reset: i_rst=1 with i_ext toggling -> o_IRQ=0, o_irq_addr=5'h1F. Release reset with no inputs -> outputs unchanged.
- Falling edge: i_reg[3:0]=4'b1100; i_ext[0] high for 3 clocks then low -> o_IRQ=1 with addr=0 two clocks after the fall. Pulse i_IRQ for 2 clocks -> o_IRQ=0, pending cleared, addr returns to 5'h1F.
- Level plus priority: src1=4'b1001, src2=4'b1100. Raise i_ext[1], i_ext[2]; drop i_ext[2] while i_ext[1] is held -> addr=1 first.
  - Ack while i_ext[1] is still high -> src1 re-asserts after service.
  - Drop i_ext[1], ack -> addr=2 is serviced next.
- Rising/both edges: src3=4'b1110; a high pulse on i_ext[3] -> two separate requests (rise, fall), each needing its own ack.
- Masking:
  - src en=0 -> input edges never assert o_IRQ.
  - i_en=0 with a pending source -> o_IRQ=0; set i_en=1 -> o_IRQ=1 next clock, correct addr.
- Reset mid-operation: assert i_rst while o_IRQ=1 and in service -> immediate o_IRQ=0, addr=5'h1F; all pending lost.
